// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if -- request/result bundle for the sequential ALU.
//
// Signals
//   start  : request, sampled by the ALU only while it is idle
//   S      : 3-bit operation select, captured with start
//   A, B   : WIDTH-bit operands, captured with start
//   Y      : registered result, holds until the next completion
//   busy   : a multi-cycle operation (SLL / MUL) is in progress
//   done   : one-cycle pulse when Y and flags update
//   flags  : {N, Z, C, V}, registered together with Y
//
// Modports
//   master : the operand side (datapath / testbench) driving requests
//   slave  : the ALU itself
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       S;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Y;
    logic             busy;
    logic             done;
    logic [3:0]       flags;

    modport master (
        output start, S, A, B,
        input  Y, busy, done, flags
    );

    modport slave (
        input  start, S, A, B,
        output Y, busy, done, flags
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered, parametrised ALU with one operation per start/done
// transaction.
//
// ADD/SUB/AND/OR/XOR/SLT complete in one clock. SLL shifts one bit per clock;
// a shift count of zero completes in one clock like the logic ops. MUL is a
// shift-add multiplier consuming one multiplier bit per clock.
//
// Build option
//   ALU_MUL_EN : when defined, S=111 runs the iterative multiplier. When not
//                defined, the multiplier is not built and S=111 completes in
//                one clock with Y=0 and flags={N,Z,C,V}=4'b0100.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : alu_seq_if.slave -- start/S/A/B in, Y/busy/done/flags out
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);

    localparam int SW = $clog2(WIDTH);      // shift-amount width
    localparam int CW = $clog2(WIDTH + 1);  // counter must hold WIDTH itself

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef ALU_MUL_EN
        ST_MUL   = 2'd2,
`endif
        ST_SHIFT = 2'd1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;         // shift accumulator
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    // Upper half accumulates partial sums; lower half starts as the
    // multiplier and is consumed from bit 0 as the product shifts right.
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     mul_sum;
`endif

    // Single-cycle datapath results
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic             alu_v;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] shl;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] y,
                                              input logic c,
                                              input logic v);
        return {y[WIDTH-1], (y == '0), c, v};
    endfunction

    assign shamt = bus.B[SW-1:0];
    assign shl   = {acc_q[WIDTH-2:0], 1'b0};

    // One-clock operations, evaluated straight from the request inputs.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        alu_y   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        add_ext = {1'b0, bus.A} + {1'b0, bus.B};
        sub_ext = {1'b0, bus.A} - {1'b0, bus.B};
        unique case (op_e'(bus.S))
            OP_ADD: begin
                alu_y = add_ext[WIDTH-1:0];
                alu_c = add_ext[WIDTH];
                // Overflow: operands agree in sign, result does not.
                alu_v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                        (add_ext[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y = sub_ext[WIDTH-1:0];
                alu_c = sub_ext[WIDTH];     // wraps exactly when A < B unsigned
                alu_v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                        (sub_ext[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND: alu_y = bus.A & bus.B;
            OP_OR:  alu_y = bus.A | bus.B;
            OP_XOR: alu_y = bus.A ^ bus.B;
            OP_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLL: alu_y = bus.A;          // only used when the count is zero
            OP_MUL: alu_y = '0;             // only used without the multiplier
            default: alu_y = '0;
        endcase
    end

    // FSM next-state and result registers
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
`ifdef ALU_MUL_EN
        mcand_d = mcand_q;
        prod_d  = prod_q;
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                  (prod_q[0] ? {1'b0, mcand_q} : '0);
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (op_e'(bus.S) == OP_SLL && shamt != '0) begin
                        acc_d   = bus.A;
                        cnt_d   = CW'(shamt);
                        state_d = ST_SHIFT;
                    end
`ifdef ALU_MUL_EN
                    else if (op_e'(bus.S) == OP_MUL) begin
                        mcand_d = bus.A;
                        prod_d  = {{WIDTH{1'b0}}, bus.B};
                        cnt_d   = CW'(WIDTH);
                        state_d = ST_MUL;
                    end
`endif
                    else begin
                        y_d     = alu_y;
                        flags_d = make_flags(alu_y, alu_c, alu_v);
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = shl;
                cnt_d = cnt_q - CW'(1);
                // Count of one means this edge performs the final shift.
                if (cnt_q == CW'(1)) begin
                    y_d     = shl;
                    flags_d = make_flags(shl, acc_q[WIDTH-1], 1'b0);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    y_d     = prod_d[WIDTH-1:0];
                    flags_d = make_flags(prod_d[WIDTH-1:0],
                                         |prod_d[2*WIDTH-1:WIDTH], 1'b0);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its _d value from before this edge.
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
`ifdef ALU_MUL_EN
            mcand_q <= '0;
            prod_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
`ifdef ALU_MUL_EN
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
`endif
        end
    end

    assign bus.Y     = y_q;
    assign bus.flags = flags_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=32).
//
// A transaction-level model computes each result with plain wide arithmetic
// and schedules its completion at the specified latency; a compare process
// checks Y/flags/busy/done against it on every negative clock edge. Directed
// sequences add hand-computed literal expectations, including the ALU_MUL_EN
// dependent multiply behaviour.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 32;

    logic clk;
    logic rst;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_op(input logic [2:0] s, input logic [W-1:0] a,
                                     input logic [W-1:0] b, output logic [W-1:0] y,
                                     output logic [3:0] f, output int lat);
        longint sa, sb, sres;
        logic [63:0] full;
        logic c, v;
        int k;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0; v = 1'b0; lat = 1; sres = 0; y = '0;
        case (s)
            3'd0: begin
                full = {32'h0, a} + {32'h0, b};
                y = full[W-1:0]; c = full[W];
                sres = sa + sb;
                v = (sres != longint'($signed(y)));
            end
            3'd1: begin
                y = a - b; c = (a < b);
                sres = sa - sb;
                v = (sres != longint'($signed(y)));
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: begin
                k = int'(b[4:0]);
                full = {32'h0, a} << k;
                y = full[W-1:0];
                c = (k == 0) ? 1'b0 : full[W];
                lat = k + 1;
            end
            default: begin
`ifdef ALU_MUL_EN
                full = {32'h0, a} * {32'h0, b};
                y = full[W-1:0];
                c = |full[63:W];
                lat = W + 1;
`else
                y = '0;
`endif
            end
        endcase
        f = {y[W-1], (y == '0), c, v};
    endfunction

    logic [W-1:0] m_y;
    logic [3:0]   m_f;
    logic         m_done, m_busy;
    bit           m_pend = 1'b0;
    longint       m_edge = 0;
    longint       m_done_edge = 0;
    logic [W-1:0] m_pend_y;
    logic [3:0]   m_pend_f;

    initial forever begin
        logic [W-1:0] r_y;
        logic [3:0]   r_f;
        int           r_lat;
        bit           was_busy;
        @(posedge clk);
        if (rst) begin
            m_pend = 1'b0; m_y = '0; m_f = '0; m_done = 1'b0; m_busy = 1'b0;
        end else begin
            was_busy = m_pend;
            m_done   = 1'b0;
            if (m_pend && m_edge == m_done_edge) begin
                m_y = m_pend_y; m_f = m_pend_f; m_done = 1'b1; m_pend = 1'b0;
            end
            if (bus.start === 1'b1 && !was_busy) begin
                model_op(bus.S, bus.A, bus.B, r_y, r_f, r_lat);
                if (r_lat == 1) begin
                    m_y = r_y; m_f = r_f; m_done = 1'b1;
                end else begin
                    m_pend = 1'b1; m_pend_y = r_y; m_pend_f = r_f;
                    m_done_edge = m_edge + longint'(r_lat) - 1;
                end
            end
            m_busy = m_pend;
        end
        m_edge++;
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cyc Y",     64'(bus.Y),     64'(m_y));
            check("cyc flags", 64'(bus.flags), 64'(m_f));
            check("cyc busy",  64'(bus.busy),  64'(m_busy));
            check("cyc done",  64'(bus.done),  64'(m_done));
            if (bus.busy === 1'b1 && bus.done === 1'b1)
                check("busy&done exclusive", 64'd1, 64'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input string name, input logic [2:0] s,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_lat, input logic [W-1:0] exp_y,
                          input logic [3:0] exp_f);
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.S = s; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " Y"},       64'(bus.Y), 64'(exp_y));
        check({name, " flags"},   64'(bus.flags), 64'(exp_f));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1;
        bus.start = 1'b0; bus.S = '0; bus.A = '0; bus.B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset Y",     64'(bus.Y), 64'd0);
        check("reset flags", 64'(bus.flags), 64'd0);
        check("reset busy",  64'(bus.busy), 64'd0);
        check("reset done",  64'(bus.done), 64'd0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle ops, flags {N,Z,C,V}
        run_op("add wrap",  3'd0, 32'hFFFF_FFFF, 32'h1, 1, 32'h0000_0000, 4'b0110);
        run_op("sub ovf",   3'd1, 32'h8000_0000, 32'h1, 1, 32'h7FFF_FFFF, 4'b0001);
        run_op("slt neg",   3'd5, 32'hFFFF_FFFF, 32'h1, 1, 32'h0000_0001, 4'b0000);
        run_op("add ovf",   3'd0, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 4'b1001);
        run_op("sub borrow",3'd1, 32'h1, 32'h2,         1, 32'hFFFF_FFFF, 4'b1010);
        run_op("slt pos",   3'd5, 32'h1, 32'hFFFF_FFFF, 1, 32'h0000_0000, 4'b0100);
        run_op("sll zero",  3'd6, 32'h5, 32'd32,        1, 32'h0000_0005, 4'b0000);
        run_op("sll carry", 3'd6, 32'h8000_0001, 32'h1, 2, 32'h0000_0002, 4'b0010);

        // SLL by 5 with an ignored start during busy
        @(negedge clk);
        bus.start = 1'b1; bus.S = 3'd6; bus.A = 32'h2; bus.B = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        check("sll busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.start = 1'b1; bus.S = 3'd0; bus.A = 32'h1; bus.B = 32'h1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 2;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("sll5 latency", 64'(lat), 64'd6);
        check("sll5 Y",       64'(bus.Y), 64'h40);
        check("sll5 flags",   64'(bus.flags), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("sll5 no extra done", 64'(bus.done), 64'd0);
        check("sll5 Y held",        64'(bus.Y), 64'h40);

        // Multiply
`ifdef ALU_MUL_EN
        run_op("mul big",  3'd7, 32'h1_0000, 32'h1_0000, 33, 32'h0, 4'b0110);
        run_op("mul 7x6",  3'd7, 32'd7, 32'd6,           33, 32'd42, 4'b0000);
`else
        run_op("mul big",  3'd7, 32'h1_0000, 32'h1_0000, 1, 32'h0, 4'b0100);
        check("mul off busy", 64'(bus.busy), 64'd0);
        run_op("mul 7x6",  3'd7, 32'd7, 32'd6,           1, 32'h0, 4'b0100);
`endif
        run_op("xor", 3'd4, 32'hA5A5, 32'h0FF0, 1, 32'hAA55, 4'b0000);

        // Reset in the middle of a multiply (asserted in cycle 10)
        @(negedge clk);
        bus.start = 1'b1; bus.S = 3'd7; bus.A = 32'd7; bus.B = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort Y",     64'(bus.Y), 64'd0);
        check("abort flags", 64'(bus.flags), 64'd0);
        check("abort busy",  64'(bus.busy), 64'd0);
        check("abort done",  64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("add after rst", 3'd0, 32'd3, 32'd4, 1, 32'd7, 4'b0000);

        // rst and start together: start dropped
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.S = 3'd0; bus.A = 32'd5; bus.B = 32'd5;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        check("rst+start done", 64'(bus.done), 64'd0);
        check("rst+start Y",    64'(bus.Y), 64'd0);
        @(posedge clk); #1;
        check("rst+start no late done", 64'(bus.done), 64'd0);

        // Back-to-back AND then OR
        @(negedge clk);
        bus.start = 1'b1; bus.S = 3'd2; bus.A = 32'hF0F0; bus.B = 32'hFF00;
        @(negedge clk);
        bus.S = 3'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        // First done (AND) was visible in the cycle just ended; check OR now.
        check("b2b or done", 64'(bus.done), 64'd1);
        check("b2b or Y",    64'(bus.Y), 64'hFFF0);
        @(posedge clk); #1;
        check("b2b idle done", 64'(bus.done), 64'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // AND result is pinned by a literal on the cycle it completes.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && bus.done === 1'b1 && bus.Y === 32'hF000)
                check("b2b and flags", 64'(bus.flags), 64'd0);
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the combinational 32-bit ALU. It accepts one operation per start/done transaction over the same 3-bit select S.
- Single-cycle logic and arithmetic ops complete in one clock.
- Shift-left and multiply are iterative multi-cycle ops.
- Status flags (zero, negative, carry, overflow) are registered with the result.
- It sits between the lab datapath's operand registers and the result/flag registers, replacing the purely combinational ALU.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥ 4).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, synchronous, active-high
- start  input  1  request; sampled only when busy=0
- S  input  3  operation select, captured with start
- A  input  WIDTH  operand A, captured with start
- B  input  WIDTH  operand B, captured with start
- Y  output  WIDTH  registered result; holds until the next completion
- busy  output  1  high while a multi-cycle op is in progress
- done  output  1  one-cycle pulse when Y/flags update
- flags  output  4  {N, Z, C, V}, registered with Y

## Operation
- S encoding:
  - 000 ADD
  - 001 SUB (A−B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (Y=1 if signed A<B, else 0)
  - 110 SLL (A shifted left by B[SW−1:0], SW=$clog2(WIDTH))
  - 111 MUL (low WIDTH bits of unsigned A×B)
- FSM states:
  - IDLE: start=1 with S∈{000..101} → compute, register Y/flags, pulse done; stay IDLE. S=110 → load shift count, go SHIFT. S=111 → load multiplicand/multiplier, go MUL.
  - SHIFT: shift accumulator left 1 bit per cycle, decrement count. When the count reaches 0, register Y/flags, pulse done, go IDLE. A count of 0 at capture completes directly from IDLE like a single-cycle op.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH iterations with a 2·WIDTH-bit accumulator. After the last iteration, register the result, pulse done, go IDLE.
- Flags:
  - Z = (Y==0); N = Y[WIDTH−1].
  - C:
    - ADD: carry-out.
    - SUB: borrow (unsigned A<B).
    - SLL: last bit shifted out (0 if count=0).
    - MUL: 1 if any product bit ≥ WIDTH is set.
    - Otherwise 0.
  - V: signed overflow for ADD/SUB; 0 otherwise.
- Arithmetic is modulo 2^WIDTH; Y never carries extra bits.
- start while busy=1 is ignored; operands and S are not re-sampled.

## Timing
- Reset values: Y=0, flags=0, busy=0, done=0, FSM=IDLE, internal counters/accumulators=0.
- Single-cycle ops and SLL with count 0: done=1 and Y valid in the cycle after the start edge. Latency 1, back-to-back throughput of 1 op/cycle.
- SLL count k>0:
  - busy=1 from the cycle after start for k cycles.
  - done=1 on the cycle after busy falls (latency k+1).
- MUL:
  - busy=1 for WIDTH cycles.
  - done at latency WIDTH+1.
- done and busy are never high in the same cycle.
- start in the same cycle done=1 is accepted (FSM is IDLE).
- rst mid-operation aborts the op and forces every reset value on the next edge. No done for the aborted op. start is accepted on the first cycle after rst deasserts.
- rst and start in the same cycle: rst wins; start is dropped.

## Configuration
- ALU_MUL_EN defined: S=111 performs the iterative multiply described above.
- ALU_MUL_EN undefined:
  - The MUL datapath and state are not built.
  - S=111 completes as a single-cycle op with Y=0, flags={0,1,0,0}, done at latency 1, busy never asserted.

## Test plan
- Reset then ADD, WIDTH=32, A=0xFFFFFFFF, B=0x1 → next cycle done=1, Y=0x00000000, flags N=0 Z=1 C=1 V=0.
- SUB A=0x80000000, B=0x1 → latency 1, Y=0x7FFFFFFF, N=0 Z=0 C=0 V=1. SLT A=0xFFFFFFFF, B=0x1 → Y=0x1.
- SLL A=0x2, B=5 → busy=1 for 5 cycles, done at cycle 6, Y=0x40, C=0. A second start during busy is ignored: no extra done, Y unchanged.
- MUL (ALU_MUL_EN) A=0x10000, B=0x10000 → busy 32 cycles, done at cycle 33, Y=0, Z=1, C=1. With the macro undefined: done at cycle 1, Y=0, busy stays 0.
- MUL A=7, B=6 with rst asserted at cycle 10 → next edge Y=0, flags=0, busy=0, no done. A fresh ADD A=3, B=4 started after reset → Y=7 at latency 1.
- Back-to-back single-cycle ops AND 0xF0F0, 0xFF00 then OR on consecutive cycles → done high two consecutive cycles, Y=0xF000 then 0xFFF0.
